axi_lite_xbar_map_ctrl: RTL

- Runtime configuration controller for the AXI4-Lite crossbar's address map and default-master-port settings.
- Software writes rules and defaults into shadow registers. A commit quiesces every crossbar slave port: it gates new AW/AR requests and drains outstanding transactions, then atomically swaps shadow into active.
- This guarantees the crossbar never sees a map or default change while an Ax beat is unserved or a transaction is in flight.
- Sits beside the crossbar; gate outputs mask valid/ready at each crossbar slave port.

---
 rtl/axi_lite_xbar_map_ctrl_pkg.sv | 16 +
 rtl/axi_pkg.sv | 10 +
 rtl/axi_lite_xbar_map_ctrl_if.sv | 31 +++
 rtl/axi_lite_xbar_txn_cnt.sv | 51 +++++
 rtl/axi_lite_xbar_map_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/axi_lite_xbar_map_ctrl_pkg.sv
// Shared types and helpers for the crossbar map controller.
package axi_lite_xbar_map_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLOSE,
        DRAIN,
        SWAP
    } state_e;

    // Width of a counter that must hold 0..max_trans inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_trans);
        return (max_trans > 0) ? $clog2(max_trans + 1) : 1;
    endfunction

endpackage

// File: rtl/axi_pkg.sv
// Minimal AXI package slice: address-rule type shared with the crossbar.
package axi_pkg;

    typedef struct packed {
        int unsigned idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } xbar_rule_64_t;

endpackage

// File: rtl/axi_lite_xbar_map_ctrl_if.sv
// Crossbar slave-port handshake taps (post-gate) and the channel gates.
interface axi_lite_xbar_map_ctrl_if #(
    parameter int unsigned NoSlvPorts = 2
) ();

    logic [NoSlvPorts-1:0] aw_valid;
    logic [NoSlvPorts-1:0] aw_ready;
    logic [NoSlvPorts-1:0] b_valid;
    logic [NoSlvPorts-1:0] b_ready;
    logic [NoSlvPorts-1:0] ar_valid;
    logic [NoSlvPorts-1:0] ar_ready;
    logic [NoSlvPorts-1:0] r_valid;
    logic [NoSlvPorts-1:0] r_ready;
    logic [NoSlvPorts-1:0] aw_gate;
    logic [NoSlvPorts-1:0] ar_gate;

    // Crossbar / integrator side: provides the taps, consumes the gates.
    modport master (
        output aw_valid, aw_ready, b_valid, b_ready,
        output ar_valid, ar_ready, r_valid, r_ready,
        input  aw_gate, ar_gate
    );

    // Controller side.
    modport slave (
        input  aw_valid, aw_ready, b_valid, b_ready,
        input  ar_valid, ar_ready, r_valid, r_ready,
        output aw_gate, ar_gate
    );

endinterface

// File: rtl/axi_lite_xbar_txn_cnt.sv
// Saturating up/down counter of outstanding transactions on one channel pair.
module axi_lite_xbar_txn_cnt
    import axi_lite_xbar_map_ctrl_pkg::*;
#(
    parameter  int unsigned MaxTrans = 8,
    localparam int unsigned CntWidth = cnt_width(MaxTrans)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic err_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                at_max, at_zero;

    assign at_max  = (cnt_q == CntWidth'(MaxTrans));
    assign at_zero = (cnt_q == '0);
    assign zero_o  = at_zero;

    // Next count: saturate at both ends and flag the attempted over/underflow.
    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (at_max) begin
                err_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (at_zero) begin
                err_o = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_lite_xbar_map_ctrl.sv
// Crossbar address-map / default-port controller: shadow config, quiesce, atomic swap.
module axi_lite_xbar_map_ctrl
    import axi_lite_xbar_map_ctrl_pkg::*;
#(
    parameter  int unsigned NoSlvPorts   = 2,
    parameter  int unsigned NoMstPorts   = 4,
    parameter  int unsigned NoAddrRules  = 4,
    parameter  int unsigned MaxTrans     = 8,
    parameter  type         rule_t       = axi_pkg::xbar_rule_64_t,
    localparam int unsigned MstIdxWidth  = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned RuleIdxWidth = (NoAddrRules > 1) ? $clog2(NoAddrRules) : 1,
    localparam int unsigned PortIdxWidth = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  cfg_rule_we_i,
    input  logic [RuleIdxWidth-1:0]               cfg_rule_idx_i,
    input  rule_t                                 cfg_rule_i,
    input  logic                                  cfg_dflt_we_i,
    input  logic [PortIdxWidth-1:0]               cfg_dflt_port_i,
    input  logic                                  cfg_dflt_en_i,
    input  logic [MstIdxWidth-1:0]                cfg_dflt_mst_i,
    input  logic                                  commit_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  cfg_err_o,
    axi_lite_xbar_map_ctrl_if.slave               tap_if,
    output rule_t [NoAddrRules-1:0]               addr_map_o,
    output logic [NoSlvPorts-1:0]                 en_default_mst_port_o,
    output logic [NoSlvPorts-1:0][MstIdxWidth-1:0] default_mst_port_o
);

    state_e                                 state_q;
    logic [NoSlvPorts-1:0]                  aw_gate_q, ar_gate_q;
    logic                                   busy_q, done_q, cfg_err_q;
    rule_t [NoAddrRules-1:0]                shadow_rule_q, active_rule_q;
    logic [NoSlvPorts-1:0]                  shadow_en_q, active_en_q;
    logic [NoSlvPorts-1:0][MstIdxWidth-1:0] shadow_mst_q, active_mst_q;

    logic [NoSlvPorts-1:0] aw_hs, b_hs, ar_hs, r_hs;
    logic [NoSlvPorts-1:0] aw_pend, ar_pend;
    logic [NoSlvPorts-1:0] w_zero, r_zero, w_err, r_err;
    logic                  all_closed, all_idle, cnt_err, cfg_req;

    assign aw_hs   = tap_if.aw_valid & tap_if.aw_ready;
    assign b_hs    = tap_if.b_valid  & tap_if.b_ready;
    assign ar_hs   = tap_if.ar_valid & tap_if.ar_ready;
    assign r_hs    = tap_if.r_valid  & tap_if.r_ready;
    assign aw_pend = tap_if.aw_valid & ~tap_if.aw_ready;
    assign ar_pend = tap_if.ar_valid & ~tap_if.ar_ready;

    assign all_closed = &{aw_gate_q, ar_gate_q};
    assign all_idle   = &{w_zero, r_zero};
    assign cnt_err    = |{w_err, r_err};
    assign cfg_req    = cfg_rule_we_i | cfg_dflt_we_i | commit_i;

    for (genvar p = 0; p < NoSlvPorts; p++) begin : g_cnt
        axi_lite_xbar_txn_cnt #(
            .MaxTrans (MaxTrans)
        ) i_wr_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .inc_i  (aw_hs[p]),
            .dec_i  (b_hs[p]),
            .zero_o (w_zero[p]),
            .err_o  (w_err[p])
        );

        axi_lite_xbar_txn_cnt #(
            .MaxTrans (MaxTrans)
        ) i_rd_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .inc_i  (ar_hs[p]),
            .dec_i  (r_hs[p]),
            .zero_o (r_zero[p]),
            .err_o  (r_err[p])
        );
    end

    // Commit sequencer: shadow writes in IDLE, close gates, drain, swap.
    // Gates start closing on the commit edge itself so that an idle crossbar
    // is fully closed one cycle after commit; a channel with a pending beat
    // keeps its gate open until that beat is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            aw_gate_q     <= '0;
            ar_gate_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            shadow_rule_q <= '0;
            active_rule_q <= '0;
            shadow_en_q   <= '0;
            active_en_q   <= '0;
            shadow_mst_q  <= '0;
            active_mst_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= cnt_err | ((state_q != IDLE) && cfg_req);
            case (state_q)
                IDLE: begin
                    if (cfg_rule_we_i) begin
                        shadow_rule_q[cfg_rule_idx_i] <= cfg_rule_i;
                    end
                    if (cfg_dflt_we_i) begin
                        shadow_en_q[cfg_dflt_port_i]  <= cfg_dflt_en_i;
                        shadow_mst_q[cfg_dflt_port_i] <= cfg_dflt_mst_i;
                    end
                    if (commit_i) begin
                        state_q   <= CLOSE;
                        busy_q    <= 1'b1;
                        aw_gate_q <= aw_gate_q | ~aw_pend;
                        ar_gate_q <= ar_gate_q | ~ar_pend;
                    end
                end
                CLOSE: begin
                    aw_gate_q <= aw_gate_q | ~aw_pend;
                    ar_gate_q <= ar_gate_q | ~ar_pend;
                    if (all_closed) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (all_idle) begin
                        state_q <= SWAP;
                    end
                end
                SWAP: begin
                    active_rule_q <= shadow_rule_q;
                    active_en_q   <= shadow_en_q;
                    active_mst_q  <= shadow_mst_q;
                    aw_gate_q     <= '0;
                    ar_gate_q     <= '0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tap_if.aw_gate        = aw_gate_q;
    assign tap_if.ar_gate        = ar_gate_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign cfg_err_o             = cfg_err_q;
    assign addr_map_o            = active_rule_q;
    assign en_default_mst_port_o = active_en_q;
    assign default_mst_port_o    = active_mst_q;

endmodule
